vector_mac_top: RTL and testbench

Streaming 4-lane unsigned INT8 dot-product accumulator. Each valid beat carries four byte pairs. The block multiplies each pair and reduces the four products to one dot product. It accumulates 250 consecutive valid beats (1000 elements) and emits the 32-bit window sum with a one-cycle `out_valid` pulse. It sits between an operand streamer and a result consumer, with no backpressure in either direction.

---
 rtl/vector_mac_top.sv | 107 ++++++++++
 tb/tb_vector_mac_top.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mac_top.sv
// vector_mac_top: streaming 4-lane unsigned INT8 dot-product accumulator.
// Five register stages: input capture, lane products, pair sums, dot product,
// and a window accumulator that emits one sum per BEATS valid beats.
module vector_mac_top #(
  parameter int BEATS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  output logic [31:0] mac_out
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // S1 state
  logic        v1_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  // S2 state
  logic        v2_reg;
  logic [15:0] prod_reg [4];
  // S3 state
  logic        v3_reg;
  logic [16:0] pair_reg [2];
  // S4 state
  logic        v4_reg;
  logic [17:0] dot_reg;
  // S5 state
  logic [31:0]   acc_reg;
  logic [CW-1:0] cnt_reg;

  // Valid flags travel alongside the data; only they (not the data) need clearing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      v4_reg <= 1'b0;
    end else begin
      v1_reg <= in_valid;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
      v4_reg <= v3_reg;
    end
  end

  // S1: capture operand words.
  always_ff @(posedge clk) begin
    a_reg <= in_a;
    b_reg <= in_b;
  end

  // S2: one 8x8 unsigned multiplier per lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // Lane product, widened before multiplying so the full 16 bits are kept.
      always_ff @(posedge clk) begin
        prod_reg[gi] <= 16'(a_reg[8*gi +: 8]) * 16'(b_reg[8*gi +: 8]);
      end
    end
  endgenerate

  // S3: first level of the reduction tree (lanes 0+1, lanes 2+3).
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      // Pair sum carries one extra bit to hold the worst-case total.
      always_ff @(posedge clk) begin
        pair_reg[gi] <= 17'(prod_reg[2*gi]) + 17'(prod_reg[2*gi+1]);
      end
    end
  endgenerate

  // S4: final reduction to the 18-bit dot product.
  always_ff @(posedge clk) begin
    dot_reg <= 18'(pair_reg[0]) + 18'(pair_reg[1]);
  end

  // S5: accumulate valid beats; on the last beat of a window publish the sum
  // and restart from zero so the next beat opens a fresh window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      mac_out   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (v4_reg) begin
        if (cnt_reg == LAST_BEAT) begin
          mac_out   <= acc_reg + 32'(dot_reg);
          out_valid <= 1'b1;
          acc_reg   <= '0;
          cnt_reg   <= '0;
        end else begin
          acc_reg <= acc_reg + 32'(dot_reg);
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_mac_top.sv
// Testbench for vector_mac_top: directed windows with hand-computed sums,
// a random soak, and mid-window reset, checked every cycle against a
// transaction-level model (window sums scheduled 4 edges after the last beat).
module tb_vector_mac_top;

  localparam int BEATS = 250;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic [31:0] mac_out;

  vector_mac_top #(.BEATS(BEATS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .mac_out(mac_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;            // number of rising edges so far
  int unsigned last_beat_edge = 0; // edge at which the most recent valid beat is sampled

  // Model state
  typedef struct {
    int unsigned at_cyc;
    logic [31:0] val;
  } ev_t;
  ev_t         evq[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_mac = '0;
  logic [31:0] m_sum = '0;
  int          m_cnt = 0;

  // Observed pulses
  logic [31:0] pulse_mac[$];
  int unsigned pulse_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at edge %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    int unsigned s = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] la = a[8*i +: 8];
      logic [7:0] lb = b[8*i +: 8];
      s += 32'(la) * 32'(lb);
    end
    return s;
  endfunction

  // Reference model: sums are formed per window of sampled beats and the
  // result becomes visible after the edge 4 cycles past the last beat.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        evq.delete();
        exp_valid = 1'b0;
        exp_mac   = '0;
        m_sum     = '0;
        m_cnt     = 0;
      end else begin
        exp_valid = 1'b0;
        if (evq.size() > 0 && evq[0].at_cyc == cyc) begin
          exp_valid = 1'b1;
          exp_mac   = evq[0].val;
          void'(evq.pop_front());
        end
        if (in_valid) begin
          m_sum += dot4(in_a, in_b);
          m_cnt++;
          if (m_cnt == BEATS) begin
            evq.push_back('{at_cyc: cyc + 4, val: m_sum});
            m_sum = '0;
            m_cnt = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        chk("mac_out", mac_out, exp_mac);
        if (out_valid === 1'b1) begin
          pulse_mac.push_back(mac_out);
          pulse_cyc.push_back(cyc);
          $display("pulse: edge %0d mac_out %0d", cyc, mac_out);
        end
      end
    end
  end

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    last_beat_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  // Checks that exactly `n` pulses appeared since index `base`, first one with `val`.
  task automatic chk_pulses(input string name, input int base, input int n, input logic [31:0] val);
    chk({name, "_count"}, 32'(pulse_mac.size() - base), 32'(n));
    if (pulse_mac.size() > base) chk({name, "_value"}, pulse_mac[base], val);
  endtask

  int base;

  initial begin
    // Reset: held low 5 cycles with random valid traffic.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_a = $urandom;
      in_b = $urandom;
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_mac_out", mac_out, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle(3);
    chk("post_reset_no_pulse", 32'(pulse_mac.size()), 32'd0);

    // Saturation window.
    base = pulse_mac.size();
    for (int i = 0; i < BEATS; i++) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(8);
    chk_pulses("saturation", base, 1, 32'd65_025_000);
    if (pulse_cyc.size() > base)
      chk("saturation_latency", 32'(pulse_cyc[base] - last_beat_edge), 32'd4);

    // Sparse single-lane window with random idle gaps.
    base = pulse_mac.size();
    beat(32'h0000_00FF, 32'h0000_00FF);
    idle($urandom_range(0, 3));
    beat(32'h1234_5678, 32'h8765_4321);
    for (int i = 0; i < BEATS - 2; i++) begin
      idle($urandom_range(0, 2));
      beat(32'h0, 32'h0);
    end
    idle(8);
    chk_pulses("sparse", base, 1, 32'd82_429);

    // Lane mapping: bytes never line up, so the dot product is zero.
    base = pulse_mac.size();
    beat(32'hFF00_0000, 32'h00FF_FFFF);
    for (int i = 0; i < BEATS - 1; i++) beat(32'h0, 32'h0);
    idle(8);
    chk_pulses("lane_map", base, 1, 32'd0);

    // Back-to-back windows.
    base = pulse_mac.size();
    for (int i = 0; i < 2 * BEATS; i++) beat(32'h0101_0101, 32'h0101_0101);
    idle(8);
    chk_pulses("b2b_first", base, 2, 32'd1000);
    if (pulse_mac.size() >= base + 2) begin
      chk("b2b_second_value", pulse_mac[base+1], 32'd1000);
      chk("b2b_spacing", 32'(pulse_cyc[base+1] - pulse_cyc[base]), 32'd250);
    end

    // Random soak, checked each cycle by the model.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom;
      in_b = $urandom;
    end
    idle(8);

    // Mid-window reset: the 100 pre-reset beats must not leak into the next sum.
    do_reset(2);
    for (int i = 0; i < 100; i++) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_reset(3);
    base = pulse_mac.size();
    for (int i = 0; i < BEATS; i++) beat(32'h0202_0202, 32'h0303_0303);
    idle(8);
    chk_pulses("mid_reset", base, 1, 32'd6000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
